// File: rtl/sound_latch_rx.sv
// Z80-side receiver of the 68000 sound command path: an 8-bit code latch with
// overrun accounting, and an IM1 interrupt request raised on SNDON rising edges.
module sound_latch_rx #(
    parameter int INT_HOLD_MAX = 0,
    parameter int OVF_WIDTH    = 4
) (
    input  logic                 clk_main,
    input  logic                 reset,
    input  logic                 snddt_n,
    input  logic [7:0]           m68k_din,
    input  logic                 sndon,
    input  logic                 z80_rd_n,
    input  logic                 z80_iorq_n,
    input  logic                 z80_m1_n,
    output logic [7:0]           z80_dout,
    output logic                 z80_int_n,
    output logic                 latch_full,
    output logic [OVF_WIDTH-1:0] ovf_count
);

    typedef enum logic [0:0] {
        IRQ_IDLE   = 1'b0,
        IRQ_ASSERT = 1'b1
    } irq_state_t;

    localparam int HOLD_W = (INT_HOLD_MAX > 1) ? $clog2(INT_HOLD_MAX) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        HOLD_W'((INT_HOLD_MAX > 0) ? (INT_HOLD_MAX - 1) : 0);
    localparam logic [HOLD_W-1:0]    HOLD_ONE  = HOLD_W'(1'b1);
    localparam logic [HOLD_W-1:0]    HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [OVF_WIDTH-1:0] OVF_ONE   = OVF_WIDTH'(1'b1);
    localparam logic [OVF_WIDTH-1:0] OVF_MAX   = {OVF_WIDTH{1'b1}};

    logic                 armed_r;
    logic                 snddt_n_d_r;
    logic                 rd_n_d_r;
    logic                 ack_d_r;
    logic                 sndon_d_r;

    logic                 ack_term_s;
    logic                 we_s;
    logic                 re_s;
    logic                 rq_s;
    logic                 ak_s;

    logic [7:0]           dout_r;
    logic                 full_r;
    logic [OVF_WIDTH-1:0] ovf_r;

    irq_state_t           state_r;
    irq_state_t           state_next_s;
    logic [HOLD_W-1:0]    hold_cnt_r;
    logic [HOLD_W-1:0]    hold_next_s;
    logic                 int_n_r;

    // Edge-detect history; armed_r masks the first cycle after reset so a
    // strobe or SNDON level already active at reset release never fires.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            armed_r     <= 1'b0;
            snddt_n_d_r <= 1'b1;
            rd_n_d_r    <= 1'b1;
            ack_d_r     <= 1'b0;
            sndon_d_r   <= 1'b0;
        end else begin
            armed_r     <= 1'b1;
            snddt_n_d_r <= snddt_n;
            rd_n_d_r    <= z80_rd_n;
            ack_d_r     <= ack_term_s;
            sndon_d_r   <= sndon;
        end
    end

    // Single-cycle event pulses derived from the edge history.
    always_comb begin
        ack_term_s = (!z80_iorq_n) && (!z80_m1_n);
        we_s       = armed_r && snddt_n_d_r && (!snddt_n);
        re_s       = armed_r && rd_n_d_r && (!z80_rd_n);
        rq_s       = armed_r && (!sndon_d_r) && sndon;
        ak_s       = armed_r && (!ack_d_r) && ack_term_s;
    end

    // Code latch: a write beats a simultaneous read, which consumes the old code.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            dout_r <= 8'h00;
            full_r <= 1'b0;
            ovf_r  <= {OVF_WIDTH{1'b0}};
        end else if (we_s) begin
            dout_r <= m68k_din;
            full_r <= 1'b1;
            if (full_r && (!re_s) && (ovf_r != OVF_MAX)) begin
                ovf_r <= ovf_r + OVF_ONE;
            end else begin
                ovf_r <= ovf_r;
            end
        end else if (re_s) begin
            full_r <= 1'b0;
        end else begin
            full_r <= full_r;
        end
    end

    // IRQ next state; a request while asserted restarts the hold window.
    always_comb begin
        state_next_s = state_r;
        hold_next_s  = hold_cnt_r;
        case (state_r)
            IRQ_IDLE: begin
                if (rq_s) begin
                    state_next_s = IRQ_ASSERT;
                    hold_next_s  = HOLD_ZERO;
                end else begin
                    hold_next_s  = HOLD_ZERO;
                end
            end
            IRQ_ASSERT: begin
                if (rq_s) begin
                    hold_next_s  = HOLD_ZERO;
                end else if (ak_s) begin
                    state_next_s = IRQ_IDLE;
                    hold_next_s  = HOLD_ZERO;
                end else if ((INT_HOLD_MAX > 0) && (hold_cnt_r == HOLD_LAST)) begin
                    state_next_s = IRQ_IDLE;
                    hold_next_s  = HOLD_ZERO;
                end else if (INT_HOLD_MAX > 0) begin
                    hold_next_s  = hold_cnt_r + HOLD_ONE;
                end else begin
                    hold_next_s  = hold_cnt_r;
                end
            end
            default: begin
                state_next_s = IRQ_IDLE;
                hold_next_s  = HOLD_ZERO;
            end
        endcase
    end

    // IRQ state, hold counter and registered INT line.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            state_r    <= IRQ_IDLE;
            hold_cnt_r <= HOLD_ZERO;
            int_n_r    <= 1'b1;
        end else begin
            state_r    <= state_next_s;
            hold_cnt_r <= hold_next_s;
            int_n_r    <= (state_next_s != IRQ_ASSERT);
        end
    end

    assign z80_dout   = dout_r;
    assign latch_full = full_r;
    assign ovf_count  = ovf_r;
    assign z80_int_n  = int_n_r;

endmodule

// File: tb/tb_sound_latch_rx.sv
// Directed scoreboard bench: dut_a holds INT until acknowledge, dut_b auto-releases
// after 8 cycles; both share the latch-side inputs.
module tb_sound_latch_rx;

    logic       clk_main = 1'b0;
    logic       reset;
    logic       snddt_n;
    logic [7:0] m68k_din;
    logic       z80_rd_n;
    logic       sndon_a, iorq_a, m1_a;
    logic       sndon_b, iorq_b, m1_b;
    logic [7:0] dout_a, dout_b;
    logic       int_a, int_b, full_a, full_b;
    logic [3:0] ovf_a, ovf_b;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] exp_ovf;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] val;
    } exp_t;
    exp_t sb[$];

    always #5 clk_main = ~clk_main;

    sound_latch_rx #(.INT_HOLD_MAX(0), .OVF_WIDTH(4)) dut_a (
        .clk_main(clk_main), .reset(reset), .snddt_n(snddt_n), .m68k_din(m68k_din),
        .sndon(sndon_a), .z80_rd_n(z80_rd_n), .z80_iorq_n(iorq_a), .z80_m1_n(m1_a),
        .z80_dout(dout_a), .z80_int_n(int_a), .latch_full(full_a), .ovf_count(ovf_a)
    );

    sound_latch_rx #(.INT_HOLD_MAX(8), .OVF_WIDTH(4)) dut_b (
        .clk_main(clk_main), .reset(reset), .snddt_n(snddt_n), .m68k_din(m68k_din),
        .sndon(sndon_b), .z80_rd_n(z80_rd_n), .z80_iorq_n(iorq_b), .z80_m1_n(m1_b),
        .z80_dout(dout_b), .z80_int_n(int_b), .latch_full(full_b), .ovf_count(ovf_b)
    );

    function automatic logic [7:0] observe(input int sel);
        case (sel)
            0: observe = dout_a;
            1: observe = {7'd0, full_a};
            2: observe = {4'd0, ovf_a};
            3: observe = {7'd0, int_a};
            4: observe = dout_b;
            5: observe = {7'd0, full_b};
            6: observe = {4'd0, ovf_b};
            7: observe = {7'd0, int_b};
            default: observe = 8'hxx;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk_main);
        #1;
    endtask

    task automatic expect_v(input string tag, input int sel, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    // Latch-side expectations apply to both instances.
    task automatic expect_latch(input string tag, input logic [7:0] d, input logic f,
                                input logic [3:0] o);
        expect_v({tag, "_dout_a"}, 0, d);
        expect_v({tag, "_full_a"}, 1, {7'd0, f});
        expect_v({tag, "_ovf_a"},  2, {4'd0, o});
        expect_v({tag, "_dout_b"}, 4, d);
        expect_v({tag, "_full_b"}, 5, {7'd0, f});
        expect_v({tag, "_ovf_b"},  6, {4'd0, o});
    endtask

    task automatic check_all();
        exp_t e;
        logic [7:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = observe(e.sel);
            n_tests++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic write_code(input logic [7:0] d, input logic with_read);
        snddt_n  = 1'b0;
        m68k_din = d;
        z80_rd_n = with_read ? 1'b0 : 1'b1;
        tick();
        snddt_n  = 1'b1;
        z80_rd_n = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b1; snddt_n = 1'b0; m68k_din = 8'hA5; z80_rd_n = 1'b1;
        sndon_a = 1'b0; iorq_a = 1'b1; m1_a = 1'b1;
        sndon_b = 1'b0; iorq_b = 1'b1; m1_b = 1'b1;
        repeat (3) tick();

        // Strobe held low through reset release must not capture.
        reset = 1'b0;
        expect_latch("reset", 8'h00, 1'b0, 4'h0);
        expect_v("reset_int_a", 3, 8'h01);
        expect_v("reset_int_b", 7, 8'h01);
        repeat (3) tick();
        check_all();
        snddt_n = 1'b1;
        tick();

        // Long strobe captures once.
        snddt_n = 1'b0; m68k_din = 8'h3C;
        expect_latch("cap3c", 8'h3C, 1'b1, 4'h0);
        tick();
        check_all();
        m68k_din = 8'hFF;
        expect_latch("hold_low", 8'h3C, 1'b1, 4'h0);
        repeat (4) tick();
        check_all();
        snddt_n = 1'b1;
        tick();

        z80_rd_n = 1'b0;
        expect_latch("read3c", 8'h3C, 1'b0, 4'h0);
        tick();
        check_all();
        z80_rd_n = 1'b1;
        tick();

        // Write, read, re-read on empty latch.
        expect_latch("wr11", 8'h11, 1'b1, 4'h0);
        write_code(8'h11, 1'b0);
        check_all();
        z80_rd_n = 1'b0;
        expect_latch("rd11", 8'h11, 1'b0, 4'h0);
        tick();
        check_all();
        z80_rd_n = 1'b1;
        tick();
        z80_rd_n = 1'b0;
        expect_latch("rd_empty", 8'h11, 1'b0, 4'h0);
        tick();
        z80_rd_n = 1'b1;
        tick();
        check_all();

        // Overrun.
        write_code(8'h22, 1'b0);
        expect_latch("ovr33", 8'h33, 1'b1, 4'h1);
        write_code(8'h33, 1'b0);
        check_all();

        // Write and read in the same cycle: no overrun.
        expect_latch("wr_rd44", 8'h44, 1'b1, 4'h1);
        write_code(8'h44, 1'b1);
        check_all();

        // Saturation.
        exp_ovf = 4'h1;
        for (int i = 0; i < 20; i++) begin
            exp_ovf = (exp_ovf == 4'hF) ? 4'hF : exp_ovf + 4'h1;
            expect_latch("sat", 8'(8'h50 + i), 1'b1, exp_ovf);
            write_code(8'(8'h50 + i), 1'b0);
            check_all();
        end
        expect_latch("sat_final", 8'h63, 1'b1, 4'hF);
        tick();
        check_all();

        // dut_a: INT held until acknowledge.
        sndon_a = 1'b1;
        expect_v("a_int_low", 3, 8'h00);
        tick();
        check_all();
        for (int i = 0; i < 1000; i++) begin
            expect_v("a_int_hold", 3, 8'h00);
            tick();
            check_all();
        end
        iorq_a = 1'b0; m1_a = 1'b0;
        expect_v("a_ack", 3, 8'h01);
        tick();
        check_all();
        expect_v("a_ack_held", 3, 8'h01);
        repeat (2) tick();
        check_all();
        iorq_a = 1'b1; m1_a = 1'b1;
        sndon_a = 1'b0;
        expect_v("a_sndon_fall", 3, 8'h01);
        repeat (2) tick();
        check_all();

        // dut_b: auto-release after exactly 8 cycles.
        sndon_b = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            sndon_b = 1'b0;
            expect_v("b_hold8", 7, (i <= 8) ? 8'h00 : 8'h01);
            check_all();
        end
        tick();

        // Retrigger at cycle 5 restarts the window.
        sndon_b = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            tick();
            sndon_b = (i == 4) ? 1'b1 : 1'b0;
            expect_v("b_retrig", 7, (i <= 12) ? 8'h00 : 8'h01);
            check_all();
        end
        tick();

        // Request and acknowledge in the same cycle keep INT asserted.
        sndon_b = 1'b1;
        tick();
        sndon_b = 1'b0;
        tick();
        sndon_b = 1'b1; iorq_b = 1'b0; m1_b = 1'b0;
        expect_v("b_rq_ak", 7, 8'h00);
        tick();
        check_all();
        iorq_b = 1'b1; m1_b = 1'b1;
        for (int i = 4; i <= 11; i++) begin
            expect_v("b_rq_ak_tail", 7, (i <= 10) ? 8'h00 : 8'h01);
            tick();
            check_all();
        end
        sndon_b = 1'b0;
        tick();

        // Reset mid-operation with INT low and latch full.
        sndon_a = 1'b1;
        expect_v("pre_reset_int", 3, 8'h00);
        tick();
        check_all();
        reset = 1'b1;
        expect_latch("midreset", 8'h00, 1'b0, 4'h0);
        expect_v("midreset_int_a", 3, 8'h01);
        tick();
        check_all();
        reset = 1'b0;
        expect_v("post_reset_int_a", 3, 8'h01);
        repeat (2) tick();
        check_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
